// File: rtl/req_shaper_pkg.sv
// Shared definitions for the request burst shaper: channel count, the
// per-channel state encoding and the beat-counter width.
package req_shaper_pkg;

  localparam int NUM_CH = 4;

  // Sized for the largest legal burst length (16), so beat indices 0..15 fit.
  localparam int BEAT_W = 4;

  // Per-channel FSM encoding (2 bits, legacy-compatible constants).
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_XFER    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // States in which the channel holds req high and may consume a grant.
  function automatic logic is_active(input logic [1:0] st);
    return (st == ST_REQ) || (st == ST_XFER);
  endfunction

endpackage

// File: rtl/req_burst_chan.sv
// One channel of the request burst shaper: queues bursts, drives req while
// work is pending, counts granted beats and releases req after BURST_LEN
// beats. Optional starvation timeout under `ifdef REQ_SHAPER_TIMEOUT_EN.
module req_burst_chan
  import req_shaper_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int PEND_W    = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              gnt,
  output logic              req,
  output logic              beat,
  output logic              done,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              starve
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              req_q, req_d;
  logic              take_beat;
  logic              last_beat;

  // A grant counts as a beat only while the channel is actually requesting;
  // stale grants seen in IDLE or RELEASE are ignored.
  always_comb begin
    take_beat = is_active(state_q) && gnt;
    last_beat = take_beat && (beat_cnt_q == LAST_BEAT);
  end

  // Next-state logic for the channel FSM and beat counter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q != '0) state_d = ST_REQ;
      end
      ST_REQ, ST_XFER: begin
        if (gnt) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = ST_RELEASE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            state_d    = ST_XFER;
          end
        end else if (state_q == ST_XFER) begin
          // Grant lost mid-burst: keep the beat count and ask again.
          state_d = ST_REQ;
        end
      end
      ST_RELEASE: begin
        // Hold req low until the arbiter has dropped the old grant.
        if (!gnt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = is_active(state_d);
  end

  // Pending-burst counter with sticky overflow; a push and a completed burst
  // in the same cycle cancel, which also lets a full counter accept a push.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (push && !last_beat) begin
      if (pend_q == PEND_MAX) ovf_d  = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (!push && last_beat) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      req_q      <= req_d;
    end
  end

  assign req      = req_q;
  assign beat     = take_beat;
  assign done     = last_beat;
  assign pending  = pend_q;
  assign overflow = ovf_q;

`ifdef REQ_SHAPER_TIMEOUT_EN
  localparam int              WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              starve_q, starve_d;

  // Count cycles spent requesting without a grant; saturate at TIMEOUT.
  always_comb begin
    wait_d   = '0;
    starve_d = starve_q;
    if (state_q == ST_REQ && !gnt) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
      if (wait_d == WAIT_MAX) starve_d = 1'b1;
    end
  end

  // Wait counter and sticky starve flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  // Without the timeout feature the flag is constant and TIMEOUT is unused.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign starve         = 1'b0;
`endif

endmodule

// File: rtl/req_burst_shaper.sv
// Request burst shaper in front of the 4-channel fixed-priority grant FSM.
// One req_burst_chan per channel; this level only slices and concatenates.
// Optional starvation timeout enabled with `define REQ_SHAPER_TIMEOUT_EN.
module req_burst_shaper
  import req_shaper_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int PEND_W    = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        push,
  input  logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        req,
  output logic [NUM_CH-1:0]        beat,
  output logic [NUM_CH-1:0]        done,
  output logic [NUM_CH*PEND_W-1:0] pending,
  output logic [NUM_CH-1:0]        overflow,
  output logic [NUM_CH-1:0]        starve
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    req_burst_chan #(
      .BURST_LEN(BURST_LEN),
      .PEND_W   (PEND_W),
      .TIMEOUT  (TIMEOUT)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .push    (push[i]),
      .gnt     (gnt[i]),
      .req     (req[i]),
      .beat    (beat[i]),
      .done    (done[i]),
      .pending (pending[i*PEND_W +: PEND_W]),
      .overflow(overflow[i]),
      .starve  (starve[i])
    );
  end

endmodule

// File: tb/tb_req_burst_shaper.sv
// Directed self-checking bench for req_burst_shaper (BURST_LEN=4, PEND_W=3,
// TIMEOUT=8). Inputs change 1 time unit after the rising edge, outputs are
// checked 1 unit later, well before the next edge.
module tb_req_burst_shaper;

  localparam int BL = 4;
  localparam int PW = 3;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    push;
  logic [3:0]    gnt;
  logic [3:0]    req;
  logic [3:0]    beat;
  logic [3:0]    done;
  logic [4*PW-1:0] pending;
  logic [3:0]    overflow;
  logic [3:0]    starve;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  req_burst_shaper #(
    .BURST_LEN(BL),
    .PEND_W   (PW),
    .TIMEOUT  (TO)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .gnt     (gnt),
    .req     (req),
    .beat    (beat),
    .done    (done),
    .pending (pending),
    .overflow(overflow),
    .starve  (starve)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pend(input int ch);
    return pending[ch*PW +: PW];
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [6:0] g_pat;
    bit [6:0] d_pat;
    g_pat = 7'b1100011;
    d_pat = 7'b1000000;

    // ---------------- reset state ----------------
    reset = 1'b1; push = '0; gnt = '0;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    check("rst_req",      req,      0);
    check("rst_beat",     beat,     0);
    check("rst_done",     done,     0);
    check("rst_pending",  pending,  0);
    check("rst_overflow", overflow, 0);
    check("rst_starve",   starve,   0);
    cyc();

    // ---------------- single burst on ch0 ----------------
    push = 4'b0001;
    #1; check("t1_req_before", req[0], 0);
    cyc(); push = '0;
    #1; check("t1_pend1", pend(0), 1);
    check("t1_req_idle", req[0], 0);
    cyc();
    #1; check("t1_req_up", req[0], 1);
    check("t1_nobeat", beat, 0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      gnt = 4'b0001;
      #1;
      check("t1_beat", beat, 4'b0001);
      check("t1_done", done, (k == 3) ? 4'b0001 : 4'b0000);
      check("t1_req_hold", req[0], 1);
      cyc();
    end
    // Stale grant still high in RELEASE: no beat, req stays low.
    #1;
    check("t1_req_rel", req[0], 0);
    check("t1_stale_beat", beat, 0);
    check("t1_pend0", pend(0), 0);
    cyc(); gnt = '0;
    #1; check("t1_req_rel2", req[0], 0);
    cyc();
    #1; check("t1_req_idle2", req[0], 0);
    cyc();

    // ---------------- back-to-back bursts on ch1 ----------------
    push = 4'b0010;
    repeat (3) cyc();
    push = '0;
    #1; check("t2_pend3", pend(1), 3);
    check("t2_req_up", req[1], 1);
    for (int b = 0; b < 3; b++) begin
      #1; check("t2_req_start", req[1], 1);
      for (int k = 0; k < 4; k++) begin
        gnt = 4'b0010;
        #1;
        check("t2_beat", beat, 4'b0010);
        check("t2_done", done, (k == 3) ? 4'b0010 : 4'b0000);
        check("t2_pend_during", pend(1), 32'(3 - b));
        cyc();
      end
      gnt = '0;
      #1;
      check("t2_gap1_req", req[1], 0);
      check("t2_pend_after", pend(1), 32'(2 - b));
      cyc();
      #1; check("t2_gap2_req", req[1], 0);
      cyc();
    end
    #1; check("t2_req_final", req[1], 0);
    check("t2_pend_final", pend(1), 0);
    cyc();

    // ---------------- overflow on ch2 ----------------
    push = 4'b0100;
    repeat (7) cyc();
    push = '0;
    #1;
    check("t3_pend7", pend(2), 7);
    check("t3_no_ovf", overflow, 0);
    check("t3_req", req[2], 1);
    // Push coinciding with done at the full count: accepted, no overflow.
    for (int k = 0; k < 4; k++) begin
      gnt  = 4'b0100;
      push = (k == 3) ? 4'b0100 : 4'b0000;
      #1;
      check("t3_beat", beat, 4'b0100);
      check("t3_pend_during", pend(2), 7);
      cyc();
    end
    gnt  = '0;
    push = 4'b0100;
    #1;
    check("t3_pend_after_done", pend(2), 7);
    check("t3_ovf_after_done", overflow, 0);
    check("t3_req_rel", req[2], 0);
    cyc();
    push = '0;
    #1;
    check("t3_ovf_set", overflow, 4'b0100);
    check("t3_pend_sat", pend(2), 7);
    check("t3_other_pend", {pend(0), pend(1), pend(3)}, 0);
    cyc();

    // ---------------- lost grant on ch3 ----------------
    push = 4'b1000;
    cyc(); push = '0;
    cyc();
    for (int i = 0; i < 7; i++) begin
      gnt = {g_pat[i], 3'b000};
      #1;
      check("t4_beat", beat, {g_pat[i], 3'b000});
      check("t4_done", done, {d_pat[i], 3'b000});
      check("t4_req",  req[3], 1);
      cyc();
    end
    gnt = '0;
    #1;
    check("t4_req_rel", req[3], 0);
    check("t4_pend0", pend(3), 0);
    cyc();

    // ---------------- reset mid-burst on ch0 ----------------
    push = 4'b0001;
    cyc(); push = '0;
    cyc();
    for (int k = 0; k < 2; k++) begin
      gnt = 4'b0001;
      #1; check("t5_beat_pre", beat, 4'b0001);
      cyc();
    end
    gnt   = 4'b0001;
    reset = 1'b1;
    #1; check("t5_no_done", done, 0);
    cyc();
    reset = 1'b0;
    gnt   = '0;
    #1;
    check("t5_req",      req,      0);
    check("t5_beat",     beat,     0);
    check("t5_done",     done,     0);
    check("t5_pending",  pending,  0);
    check("t5_overflow", overflow, 0);
    check("t5_starve",   starve,   0);
    push = 4'b0001;
    cyc(); push = '0;
    #1; check("t5_pend1", pend(0), 1);
    cyc();
    #1; check("t5_req_up", req[0], 1);
    for (int k = 0; k < 4; k++) begin
      gnt = 4'b0001;
      #1;
      check("t5_re_beat", beat, 4'b0001);
      check("t5_re_done", done, (k == 3) ? 4'b0001 : 4'b0000);
      cyc();
    end
    gnt = '0;
    #1; check("t5_pend0", pend(0), 0);
    cyc();

    // ---------------- starvation timeout on ch2 ----------------
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    push  = 4'b0100;
    cyc(); push = '0;
    cyc();
    #1; check("t6_req_up", req[2], 1);
`ifdef REQ_SHAPER_TIMEOUT_EN
    repeat (7) cyc();
    #1; check("t6_starve_pre", starve, 0);
    cyc();
    #1; check("t6_starve_set", starve, 4'b0100);
    for (int k = 0; k < 4; k++) begin
      gnt = 4'b0100;
      cyc();
    end
    gnt = '0;
    repeat (3) cyc();
    #1; check("t6_starve_sticky", starve, 4'b0100);
`else
    repeat (12) cyc();
    #1; check("t6_starve_off", starve, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
